uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit path between N_REQ byte-stream requesters, e.g. the S3 send controller and the string matcher.
- Replaces static SW0 muxing with packet-locked round-robin arbitration.
- A grant is held from a requester's first byte until its req_last byte is accepted, so messages never interleave.
- Sits between the requesters and the uart_send serializer, and drives its valid/ready byte handshake.

---
 rtl/uart_pkg.sv | 17 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, system clock rate, arbiter state
// encoding and a millisecond-to-cycle helper for timeout parameters.
package uart_pkg;

   localparam int BYTE_W = 8;
   localparam int CLK_HZ = 100_000_000;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_t;

   function automatic int ms_to_cycles(input int ms);
      return (CLK_HZ / 1000) * ms;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request (one-hot)
// searching upward from last_grant+1, wrapping modulo N_REQ.
module rr_pick #(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] last_grant,
   output logic [N_REQ-1:0]         onehot,
   output logic                     any
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0] idx;

   always_comb begin
      onehot = '0;
      any    = 1'b0;
      idx    = '0;
      // Offset N_REQ wraps back to last_grant itself, so it is re-picked only
      // when nobody else is asking.
      for (int k = 1; k <= N_REQ; k++) begin
         idx = IDX_W'((int'(last_grant) + k) % N_REQ);
         if (!any && req[idx]) begin
            onehot[idx] = 1'b1;
            any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of uart_send; a grant is held
// until the owner's req_last byte. Optional forced owner: UART_TX_ARB_FORCE_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ        = 2,
   parameter int DATA_W       = BYTE_W,
   parameter int LOCK_TIMEOUT = ms_to_cycles(10)
) (
   input  logic                       clk,
   input  logic                       rst,
`ifdef UART_TX_ARB_FORCE_EN
   input  logic                       force_en,
   input  logic [$clog2(N_REQ)-1:0]   force_sel,
`endif
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*DATA_W-1:0]    req_data,
   input  logic [N_REQ-1:0]           req_last,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       tx_valid,
   output logic [DATA_W-1:0]          tx_data,
   input  logic                       tx_ready,
   output logic [N_REQ-1:0]           grant,
   output logic                       busy,
   output logic                       timeout_pulse
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

   // Handshake: a byte moves on any cycle with valid && ready on the same
   // side; valid never waits for ready, and grant is frozen while the owner
   // holds a byte that tx_ready has not yet taken.
   arb_state_t         state_q, state_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pulse_q, pulse_d;

   logic [N_REQ-1:0]   pick_onehot, sel_onehot;
   logic               pick_any, sel_any;
   logic [IDX_W-1:0]   sel_idx;
   logic               owner_valid, owner_last, xfer;

   rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
      .req        (req_valid),
      .last_grant (last_q),
      .onehot     (pick_onehot),
      .any        (pick_any)
   );

   always_comb begin
      sel_onehot = pick_onehot;
      sel_any    = pick_any;
`ifdef UART_TX_ARB_FORCE_EN
      if (force_en) begin
         sel_onehot            = '0;
         sel_onehot[force_sel] = req_valid[force_sel];
         sel_any               = req_valid[force_sel];
      end
`endif
      sel_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (sel_onehot[i]) sel_idx = IDX_W'(i);
      end
   end

   assign owner_valid   = req_valid[owner_q];
   assign owner_last    = req_last[owner_q];
   assign tx_valid      = |(grant_q & req_valid);
   assign tx_data       = (state_q == ARB_LOCK) ? req_data[int'(owner_q)*DATA_W +: DATA_W] : '0;
   assign req_ready     = grant_q & {N_REQ{tx_ready}};
   assign xfer          = tx_valid && tx_ready;
   assign grant         = grant_q;
   assign busy          = (state_q == ARB_LOCK);
   assign timeout_pulse = pulse_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (sel_any) begin
               state_d = ARB_LOCK;
               grant_d = sel_onehot;
               owner_d = sel_idx;
               cnt_d   = '0;
            end
         end
         ARB_LOCK: begin
            if (xfer && owner_last) begin
               state_d = ARB_IDLE;
               grant_d = '0;
               last_d  = owner_q;
               cnt_d   = '0;
            end else if (owner_valid) begin
               cnt_d = '0;
            end else if (cnt_q >= CNT_LAST) begin
               // Revocation happens at the top count, so the counter never wraps.
               state_d = ARB_IDLE;
               grant_d = '0;
               last_d  = owner_q;
               cnt_d   = '0;
               pulse_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         last_q  <= IDX_W'(N_REQ - 1);
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round-robin order, packet lock,
// backpressure, lock timeout, async reset and (when built with it) forced owner.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_last;
   logic [1:0]  req_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b1;
   logic [1:0]  grant;
   logic        busy;
   logic        timeout_pulse;
`ifdef UART_TX_ARB_FORCE_EN
   logic        force_en  = 1'b0;
   logic        force_sel = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   logic [8:0] src0_q[$];
   logic [8:0] src1_q[$];
   logic [7:0] exp_q[$];
   logic [1:0] exp_g_q[$];

   uart_tx_arbiter #(
      .N_REQ        (2),
      .DATA_W       (8),
      .LOCK_TIMEOUT (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
`ifdef UART_TX_ARB_FORCE_EN
      .force_en      (force_en),
      .force_sel     (force_sel),
`endif
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .tx_ready      (tx_ready),
      .grant         (grant),
      .busy          (busy),
      .timeout_pulse (timeout_pulse)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // requester drivers: present queue heads, pop on accepted bytes
   initial begin
      logic [1:0] acc;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         acc = req_valid & req_ready;
         @(posedge clk);
         #1;
         if (acc[0] && src0_q.size() > 0) void'(src0_q.pop_front());
         if (acc[1] && src1_q.size() > 0) void'(src1_q.pop_front());
         if (src0_q.size() > 0) begin
            req_valid[0] = 1'b1;
            {req_last[0], req_data[7:0]} = src0_q[0];
         end else begin
            req_valid[0] = 1'b0;
            req_last[0]  = 1'b0;
         end
         if (src1_q.size() > 0) begin
            req_valid[1] = 1'b1;
            {req_last[1], req_data[15:8]} = src1_q[0];
         end else begin
            req_valid[1] = 1'b0;
            req_last[1]  = 1'b0;
         end
      end
   end

   // scoreboard: every transfer must match the next expected byte and owner
   initial begin
      logic [7:0] e;
      logic [1:0] g;
      forever begin
         @(negedge clk);
         if (rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               g = exp_g_q.pop_front();
               check("sb_data", 32'(tx_data), 32'(e));
               check("sb_grant", 32'(grant), 32'(g));
            end
         end
      end
   end

   task automatic push_req(input int r, input logic [7:0] d, input logic last);
      if (r == 0) src0_q.push_back({last, d});
      else        src1_q.push_back({last, d});
   endtask

   task automatic expect_byte(input logic [7:0] d, input logic [1:0] g);
      exp_q.push_back(d);
      exp_g_q.push_back(g);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_xfer(input string tag);
      int found;
      found = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (tx_valid && tx_ready) begin
            found = 1;
            break;
         end
      end
      check({tag, "_xfer"}, 32'(found), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int found;
      found = 0;
      for (int k = 0; k < 300; k++) begin
         step();
         if (!busy && src0_q.size() == 0 && src1_q.size() == 0 && exp_q.size() == 0) begin
            found = 1;
            break;
         end
      end
      check({tag, "_idle"}, 32'(found), 32'd1);
   endtask

   task automatic flush_queues();
      src0_q.delete();
      src1_q.delete();
      exp_q.delete();
      exp_g_q.delete();
   endtask

   initial begin
      int stable;
      int seen;
      int n;

      // reset state
      #12;
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_pulse", 32'(timeout_pulse), 32'd0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      step();

      // single requester, three bytes back to back
      push_req(0, 8'h31, 1'b0);
      push_req(0, 8'h32, 1'b0);
      push_req(0, 8'h33, 1'b1);
      expect_byte(8'h31, 2'b01);
      expect_byte(8'h32, 2'b01);
      expect_byte(8'h33, 2'b01);
      step();
      step();
      check("single_grant", 32'(grant), 32'd1);
      check("single_busy", 32'(busy), 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("single_consecutive", 32'(tx_valid && tx_ready), 32'd1);
      end
      step();
      check("single_end_grant", 32'(grant), 32'd0);
      check("single_end_busy", 32'(busy), 32'd0);
      wait_idle("single");

      // contention straight after reset: req0 first, one idle cycle, then req1
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      flush_queues();
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      step();
      push_req(0, 8'h10, 1'b0);
      push_req(0, 8'h11, 1'b1);
      push_req(1, 8'h20, 1'b0);
      push_req(1, 8'h21, 1'b1);
      expect_byte(8'h10, 2'b01);
      expect_byte(8'h11, 2'b01);
      expect_byte(8'h20, 2'b10);
      expect_byte(8'h21, 2'b10);
      step();
      step();
      check("cont_first_grant", 32'(grant), 32'd1);
      step();
      step();
      check("cont_gap_grant", 32'(grant), 32'd0);
      check("cont_gap_busy", 32'(busy), 32'd0);
      step();
      check("cont_second_grant", 32'(grant), 32'd2);
      wait_idle("cont1");

      // req0 served last, so a simultaneous round now starts with req1
      push_req(0, 8'h60, 1'b1);
      expect_byte(8'h60, 2'b01);
      wait_idle("solo");
      push_req(0, 8'h40, 1'b1);
      push_req(1, 8'h50, 1'b1);
      expect_byte(8'h50, 2'b10);
      expect_byte(8'h40, 2'b01);
      step();
      step();
      check("cont2_first_grant", 32'(grant), 32'd2);
      wait_idle("cont2");

      // backpressure longer than the lock timeout must not disturb anything
      push_req(0, 8'hA0, 1'b0);
      push_req(0, 8'hA1, 1'b0);
      push_req(0, 8'hA2, 1'b1);
      expect_byte(8'hA0, 2'b01);
      expect_byte(8'hA1, 2'b01);
      expect_byte(8'hA2, 2'b01);
      wait_xfer("bp_first");
      step();
      tx_ready = 1'b0;
      stable = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (tx_valid && tx_data == 8'hA1 && grant == 2'b01 && busy && !timeout_pulse) stable++;
      end
      check("bp_stable", 32'(stable), 32'd50);
      step();
      tx_ready = 1'b1;
      wait_idle("bp");

      // lock timeout: req1 goes silent mid-packet while req0 waits
      push_req(1, 8'h77, 1'b0);
      expect_byte(8'h77, 2'b10);
      wait_xfer("to_first");
      step();
      push_req(0, 8'h88, 1'b1);
      expect_byte(8'h88, 2'b01);
      seen = 0;
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         step();
         n = k;
         if (k == 5) check("to_nonowner_ready", 32'(req_ready), 32'd2);
         if (timeout_pulse) begin
            seen = 1;
            break;
         end
      end
      check("to_seen", 32'(seen), 32'd1);
      check("to_delay", 32'(n), 32'd16);
      check("to_grant_clear", 32'(grant), 32'd0);
      check("to_busy", 32'(busy), 32'd0);
      step();
      check("to_pulse_width", 32'(timeout_pulse), 32'd0);
      check("to_regrant", 32'(grant), 32'd1);
      wait_idle("to");

      // asynchronous reset between edges in the middle of a packet
      push_req(1, 8'hC0, 1'b0);
      push_req(1, 8'hC1, 1'b0);
      push_req(1, 8'hC2, 1'b1);
      expect_byte(8'hC0, 2'b10);
      wait_xfer("ar_first");
      step();
      #1;
      rst = 1'b0;
      #1;
      check("ar_tx_valid", 32'(tx_valid), 32'd0);
      check("ar_grant", 32'(grant), 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_req_ready", 32'(req_ready), 32'd0);
      flush_queues();
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      step();
      push_req(1, 8'hD0, 1'b1);
      expect_byte(8'hD0, 2'b10);
      step();
      step();
      check("ar_regrant", 32'(grant), 32'd2);
      wait_idle("ar");

`ifdef UART_TX_ARB_FORCE_EN
      // forced owner: only req1 while selected; switch waits for its last byte
      force_en  = 1'b1;
      force_sel = 1'b1;
      push_req(0, 8'hE0, 1'b0);
      push_req(0, 8'hE1, 1'b1);
      push_req(1, 8'hF0, 1'b0);
      push_req(1, 8'hF1, 1'b1);
      expect_byte(8'hF0, 2'b10);
      expect_byte(8'hF1, 2'b10);
      expect_byte(8'hE0, 2'b01);
      expect_byte(8'hE1, 2'b01);
      step();
      step();
      check("force_grant", 32'(grant), 32'd2);
      wait_xfer("force_first");
      step();
      force_sel = 1'b0;
      #1;
      check("force_hold", 32'(grant), 32'd2);
      step();
      check("force_gap", 32'(grant), 32'd0);
      step();
      check("force_switch", 32'(grant), 32'd1);
      wait_idle("force");
      force_en = 1'b0;
`endif

      check("sb_left", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
